// File: rtl/elevator_controller.sv
// elevator_controller: four-floor SCAN elevator sequencer with timed motor, arrival and door phases
module elevator_controller #(
  parameter int MOVE_TICKS   = 8,
  parameter int DOOR_TICKS   = 6,
  parameter int ARRIVE_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] call,
  output logic [3:0] BCD,
  output logic [2:0] floor,
  output logic [3:0] pending,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_open
);
  typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, ARRIVE, OPEN, CLOSE} state_t;
  state_t      state;
  logic [1:0]  fl;
  logic        dir;
  logic [15:0] timer;
  logic [1:0]  nxt;
  logic [3:0]  hit, latched, served;
  logic        above, below, move_done, door_done, arrive_done;
  assign nxt         = state == MOVE_DOWN ? fl - 2'd1 : fl + 2'd1;
  assign hit         = 4'd1 << fl;
  assign latched     = pending | call;
  assign served      = latched & ~hit;
  assign above       = |(pending & ~((4'd2 << fl) - 4'd1));
  assign below       = |(pending & ((4'd1 << fl) - 4'd1));
  assign move_done   = timer == 16'(MOVE_TICKS - 1);
  assign door_done   = timer == 16'(DOOR_TICKS - 1);
  assign arrive_done = timer == 16'(ARRIVE_TICKS - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      fl      <= 2'd0;
      pending <= 4'd0;
      dir     <= 1'b1;
      timer   <= 16'd0;
    end else begin
      pending <= latched;
      timer   <= timer + 16'd1;
      case (state)
        IDLE: begin
          timer <= 16'd0;
          if (pending[fl]) begin
            state   <= OPEN;
            pending <= served;
          end else if (above && (dir || !below)) begin
            dir   <= 1'b1;
            state <= MOVE_UP;
          end else if (below) begin
            dir   <= 1'b0;
            state <= MOVE_DOWN;
          end
        end
        MOVE_UP, MOVE_DOWN:
          if (move_done) begin
            timer <= 16'd0;
            fl    <= nxt;
            if (pending[nxt] || nxt == (state == MOVE_UP ? 2'd3 : 2'd0)) state <= ARRIVE;
          end
        ARRIVE:
          if (arrive_done) begin
            timer   <= 16'd0;
            state   <= OPEN;
            pending <= served;
          end
        OPEN: begin
          pending <= served;
          if (call[fl]) timer <= 16'd0;
          else if (door_done) begin
            timer <= 16'd0;
            state <= CLOSE;
          end
        end
        CLOSE:
          if (call[fl]) begin
            timer   <= 16'd0;
            state   <= OPEN;
            pending <= served;
          end else if (door_done) begin
            timer <= 16'd0;
            if (dir ? above : below) state <= dir ? MOVE_UP : MOVE_DOWN;
            else if (dir ? below : above) begin
              dir   <= !dir;
              state <= dir ? MOVE_DOWN : MOVE_UP;
            end else state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  assign BCD = state == MOVE_UP   ? 4'd5 :
               state == MOVE_DOWN ? 4'd8 :
               state == ARRIVE    ? {2'b00, fl} + 4'd1 :
               state == OPEN      ? 4'd6 :
               state == CLOSE     ? 4'd7 : 4'd0;
  assign floor      = {1'b0, fl} + 3'd1;
  assign motor_up   = state == MOVE_UP;
  assign motor_down = state == MOVE_DOWN;
  assign door_open  = state == OPEN;
endmodule

// File: tb/tb_elevator_controller.sv
// tb_elevator_controller: directed scenario checks of the elevator sequencer
module tb_elevator_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] call = 4'd0;
  logic [3:0] bcd;
  logic [2:0] floor;
  logic [3:0] pending;
  logic       motor_up, motor_down, door_open;
  int passed = 0;
  int total = 0;
  logic [3:0] seq [32];
  logic [2:0] stops [8];
  int seq_n, stop_n;
  logic timed_out;

  elevator_controller #(.MOVE_TICKS(4), .DOOR_TICKS(3), .ARRIVE_TICKS(2)) dut (
    .clk(clk), .reset(reset), .call(call), .BCD(bcd), .floor(floor), .pending(pending),
    .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open)
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    @(negedge clk);
    reset = 1'b1;
    call = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic trace(input int limit);
    seq_n = 1;
    stop_n = 0;
    timed_out = 1'b1;
    foreach (seq[i]) seq[i] = 4'hf;
    foreach (stops[i]) stops[i] = 3'd0;
    seq[0] = bcd;
    for (int c = 0; c < limit; c++) begin
      tick();
      if (bcd !== seq[seq_n-1] && seq_n < 32) begin
        if (bcd == 4'd6 && stop_n < 8) begin
          stops[stop_n] = floor;
          stop_n++;
        end
        seq[seq_n] = bcd;
        seq_n++;
      end
      if (bcd == 4'd0 && seq_n > 1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task test_reset;
    do_reset();
    call = 4'b0100;
    tick();
    call = 4'd0;
    tick();
    tick();
    total++; if (bcd !== 4'd5) $display("FAIL reset_pre_bcd got %0d want 5", bcd); else passed++;
    total++; if (motor_up !== 1'b1) $display("FAIL reset_pre_motor got %0b want 1", motor_up); else passed++;
    #3 reset = 1'b1;
    #1;
    total++; if (bcd !== 4'd0) $display("FAIL reset_bcd got %0d want 0", bcd); else passed++;
    total++; if (floor !== 3'd1) $display("FAIL reset_floor got %0d want 1", floor); else passed++;
    total++; if (pending !== 4'd0) $display("FAIL reset_pending got %b want 0000", pending); else passed++;
    total++; if ({motor_up, motor_down, door_open} !== 3'b000) $display("FAIL reset_outs got %b want 000", {motor_up, motor_down, door_open}); else passed++;
    #2 reset = 1'b0;
    tick();
    total++; if (bcd !== 4'd0 || pending !== 4'd0) $display("FAIL reset_after got bcd=%0d pend=%b want 0/0000", bcd, pending); else passed++;
  endtask

  task automatic test_single_trip;
    logic [3:0] eb [17];
    logic [2:0] ef [17];
    eb = '{5,5,5,5,5,5,5,5,3,3,6,6,6,7,7,7,0};
    ef = '{1,1,1,1,2,2,2,2,3,3,3,3,3,3,3,3,3};
    do_reset();
    call = 4'b0100;
    tick();
    call = 4'd0;
    total++; if (pending !== 4'b0100 || bcd !== 4'd0) $display("FAIL trip_latch got pend=%b bcd=%0d want 0100/0", pending, bcd); else passed++;
    for (int i = 0; i < 17; i++) begin
      tick();
      total++; if (bcd !== eb[i]) $display("FAIL trip_bcd cyc%0d got %0d want %0d", i + 1, bcd, eb[i]); else passed++;
      total++; if (floor !== ef[i]) $display("FAIL trip_floor cyc%0d got %0d want %0d", i + 1, floor, ef[i]); else passed++;
      total++; if (door_open !== (eb[i] == 4'd6) || motor_up !== (eb[i] == 4'd5) || motor_down !== 1'b0)
        $display("FAIL trip_outs cyc%0d got up=%0b dn=%0b door=%0b want up=%0b dn=0 door=%0b", i + 1, motor_up, motor_down, door_open, eb[i] == 4'd5, eb[i] == 4'd6);
      else passed++;
    end
    total++; if (pending !== 4'd0) $display("FAIL trip_pending_end got %b want 0000", pending); else passed++;
  endtask

  task test_door_hold;
    do_reset();
    call = 4'b0001;
    tick();
    call = 4'd0;
    total++; if (bcd !== 4'd0 || pending !== 4'b0001) $display("FAIL hold_latch got bcd=%0d pend=%b want 0/0001", bcd, pending); else passed++;
    tick();
    total++; if (bcd !== 4'd6 || door_open !== 1'b1) $display("FAIL hold_open got bcd=%0d door=%0b want 6/1", bcd, door_open); else passed++;
    total++; if (pending !== 4'd0 || motor_up !== 1'b0 || floor !== 3'd1) $display("FAIL hold_nomove got pend=%b up=%0b floor=%0d want 0000/0/1", pending, motor_up, floor); else passed++;
    tick();
    call = 4'b0001;
    tick();
    call = 4'd0;
    total++; if (door_open !== 1'b1 || pending !== 4'd0) $display("FAIL hold_restart got door=%0b pend=%b want 1/0000", door_open, pending); else passed++;
    tick();
    total++; if (door_open !== 1'b1) $display("FAIL hold_open2 got %0b want 1", door_open); else passed++;
    tick();
    total++; if (door_open !== 1'b1) $display("FAIL hold_open3 got %0b want 1", door_open); else passed++;
    tick();
    total++; if (bcd !== 4'd7 || door_open !== 1'b0) $display("FAIL hold_close got bcd=%0d door=%0b want 7/0", bcd, door_open); else passed++;
  endtask

  task automatic test_scan;
    logic [3:0] es [13];
    es = '{5,3,6,7,5,4,6,7,8,1,6,7,0};
    do_reset();
    call = 4'b1000;
    tick();
    call = 4'd0;
    for (int i = 0; i < 6; i++) tick();
    total++; if (floor !== 3'd2 || bcd !== 4'd5) $display("FAIL scan_setup got floor=%0d bcd=%0d want 2/5", floor, bcd); else passed++;
    call = 4'b0101;
    tick();
    call = 4'd0;
    total++; if (pending !== 4'b1101) $display("FAIL scan_pending got %b want 1101", pending); else passed++;
    trace(300);
    total++; if (timed_out) $display("FAIL scan_timeout got no idle want idle within 300 cycles"); else passed++;
    total++; if (seq_n !== 13) $display("FAIL scan_len got %0d want 13", seq_n); else passed++;
    for (int i = 0; i < 13; i++) begin
      total++; if (seq[i] !== es[i]) $display("FAIL scan_seq[%0d] got %0d want %0d", i, seq[i], es[i]); else passed++;
    end
    total++; if (stop_n !== 3 || stops[0] !== 3'd3 || stops[1] !== 3'd4 || stops[2] !== 3'd1)
      $display("FAIL scan_stops got n=%0d %0d,%0d,%0d want 3: 3,4,1", stop_n, stops[0], stops[1], stops[2]);
    else passed++;
    total++; if (pending !== 4'd0) $display("FAIL scan_pending_end got %b want 0000", pending); else passed++;
  endtask

  task test_reopen;
    logic found;
    do_reset();
    call = 4'b0010;
    tick();
    call = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      found = bcd == 4'd7;
    end
    total++; if (!found) $display("FAIL reopen_reach_close got bcd=%0d want 7 within 100 cycles", bcd); else passed++;
    tick();
    call = 4'b0010;
    tick();
    call = 4'd0;
    total++; if (bcd !== 4'd6 || floor !== 3'd2 || pending !== 4'd0) $display("FAIL reopen_open got bcd=%0d floor=%0d pend=%b want 6/2/0000", bcd, floor, pending); else passed++;
    tick();
    total++; if (bcd !== 4'd6) $display("FAIL reopen_open2 got %0d want 6", bcd); else passed++;
    tick();
    total++; if (bcd !== 4'd6) $display("FAIL reopen_open3 got %0d want 6", bcd); else passed++;
    tick();
    total++; if (bcd !== 4'd7) $display("FAIL reopen_close got %0d want 7", bcd); else passed++;
  endtask

  task automatic test_simultaneous;
    logic [3:0] es [10];
    es = '{0,5,4,6,7,8,1,6,7,0};
    do_reset();
    call = 4'b0010;
    tick();
    call = 4'd0;
    trace(200);
    total++; if (timed_out || floor !== 3'd2) $display("FAIL simul_setup got floor=%0d timeout=%0b want 2/0", floor, timed_out); else passed++;
    call = 4'b1001;
    tick();
    call = 4'd0;
    total++; if (pending !== 4'b1001 || bcd !== 4'd0) $display("FAIL simul_latch got pend=%b bcd=%0d want 1001/0", pending, bcd); else passed++;
    trace(300);
    total++; if (timed_out) $display("FAIL simul_timeout got no idle want idle within 300 cycles"); else passed++;
    total++; if (seq_n !== 10) $display("FAIL simul_len got %0d want 10", seq_n); else passed++;
    for (int i = 0; i < 10; i++) begin
      total++; if (seq[i] !== es[i]) $display("FAIL simul_seq[%0d] got %0d want %0d", i, seq[i], es[i]); else passed++;
    end
    total++; if (stop_n !== 2 || stops[0] !== 3'd4 || stops[1] !== 3'd1)
      $display("FAIL simul_stops got n=%0d %0d,%0d want 2: 4,1", stop_n, stops[0], stops[1]);
    else passed++;
    total++; if (pending !== 4'd0 || floor !== 3'd1) $display("FAIL simul_end got pend=%b floor=%0d want 0000/1", pending, floor); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_trip();
    test_door_hold();
    test_scan();
    test_reopen();
    test_simultaneous();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/elevator_controller.md
# elevator_controller

Four-floor elevator sequencer. It latches floor calls and moves the car between floors 1–4 with a directional (SCAN) policy. It times the motor and door phases and drives the 4-bit status code consumed by the team's BCD-to-7-segment display decoder. It sits between the call buttons and the display decoder, and owns the motor and door outputs.

## Interface
- MOVE_TICKS, 8: cycles to travel one floor; legal range 1..65535.
- DOOR_TICKS, 6: cycles the door stays open, and cycles the door takes to close; legal range 1..65535.
- ARRIVE_TICKS, 2: cycles the arrival floor number is shown before the door opens; legal range 1..65535.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- call  in  4  floor call buttons; bit i is floor i+1; level or pulse, sampled every edge.
- BCD  out  4  status code to the display decoder:
  - 0: waiting
  - 1–4: floor number
  - 5: going up
  - 6: door open
  - 7: door closing
  - 8: going down
  - 9: never emitted.
- floor  out  3  current floor, 1..4.
- pending  out  4  latched, unserved calls.
- motor_up  out  1  high in MOVE_UP.
- motor_down  out  1  high in MOVE_DOWN.
- door_open  out  1  high in OPEN.

## Operation
- **Reset values:** state IDLE, floor=1, pending=0, dir=up, timer=0, BCD=0, motor_up=motor_down=door_open=0. After reset the car is taken to be at floor 1.
- **Call latching:** every edge, pending |= call. The only exception is the bit of the current floor on the edge that enters OPEN, or while in OPEN; for that bit, clear wins over set.
- **Outputs:** all outputs are decoded from registered state, floor and pending only. There is no combinational input-to-output path.
- **States:**
  - **IDLE** (BCD=0):
    - If pending[floor] is set, go to OPEN.
    - Otherwise, if there is a call above and (dir=up or no call below), set dir=up and go to MOVE_UP.
    - Otherwise, if there is a call below, set dir=down and go to MOVE_DOWN.
    - Otherwise stay in IDLE.
  - **MOVE_UP / MOVE_DOWN** (BCD=5 / 8):
    - Each floor step lasts MOVE_TICKS cycles; at the end of a step, floor ±1.
    - If pending[new floor] is set, go to ARRIVE; otherwise start the next step.
    - floor never goes below 1 or above 4; a move is only entered when a call exists in that direction.
  - **ARRIVE** (BCD=floor): lasts ARRIVE_TICKS cycles, then go to OPEN.
  - **OPEN** (BCD=6, door_open=1):
    - pending[floor] is cleared on entry.
    - Lasts DOOR_TICKS cycles.
    - A call to the current floor during OPEN restarts the timer (the door stays open a full DOOR_TICKS after the last such call).
  - **CLOSE** (BCD=7): lasts DOOR_TICKS cycles.
    - A call to the current floor during CLOSE returns the block to OPEN on the next edge.
    - At the end of CLOSE, apply the SCAN decision:
      - continue in dir if a call exists in that direction;
      - else reverse if a call exists in the other direction;
      - else go to IDLE.
- **Timer:** 16-bit. It clears on every state change and on every floor step. A timed state of N ticks is exited on the edge where timer==N-1.
- **Simultaneous calls:** calls above and below in IDLE resolve by dir (up after reset).

## Timing
- **Call to motion:** a call sampled at edge t sets pending at t. IDLE acts at edge t+1, so motor_up or motor_down is high after edge t+1.
- **Call at the current floor in IDLE:** door_open is high after edge t+1.
- **Dwell times:** a trip of k floors spends exactly k·MOVE_TICKS cycles in MOVE. A stop costs ARRIVE_TICKS + 2·DOOR_TICKS cycles.
- **Reset mid-operation:** reset asserted in any state forces the reset values asynchronously, without waiting for a clock edge. Normal operation resumes on the first edge after reset deasserts.

## Test plan
All scenarios use MOVE_TICKS=4, DOOR_TICKS=3, ARRIVE_TICKS=2.

1. **Reset:** assert reset mid-cycle. Outputs show BCD=0, floor=1, pending=0 and all motor/door outputs low before the next edge.
2. **Single trip:** 1-cycle pulse of call=4'b0100 at floor 1. Required response:
   - BCD=5 for 8 cycles; floor becomes 2 after 4 cycles and 3 after 8.
   - BCD=3 for 2 cycles.
   - BCD=6 with door_open=1 for 3 cycles.
   - BCD=7 for 3 cycles.
   - Then BCD=0 and pending=0.
3. **Call at current floor / door hold:** call=4'b0001 in IDLE at floor 1 gives OPEN one edge later, with no motion. Repeat call[0] at OPEN cycle 2: door_open stays high 3 more cycles.
4. **SCAN order:** car at floor 2 moving up, with pending floor 4. Set call bits for floor 1 and floor 3. Required stop order: floor 3, floor 4, then floor 1, with BCD going 5→3→6→7→5→4→6→7→8… and pending=0 at the end.
5. **Reopen during close:** call for the current floor during the 2nd cycle of CLOSE returns to BCD=6 next edge, with a full 3-cycle OPEN.
6. **Simultaneous calls:** from IDLE at floor 2 after reset, call=4'b1001 together. The car moves up first (BCD=5), serves floor 4, then goes down to floor 1.
